// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: 14-state FSM that sequences fetch, decode and
// per-class execute/writeback, with memory handshake stalls and a HALT trap.
module mips_multicycle_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] MemtoReg,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_retired,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JAL      = 4'd9,
        S_JR       = 4'd10,
        S_I_EX     = 4'd11,
        S_I_WB     = 4'd12,
        S_HALT     = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_e state_q, state_d;
    logic   rtype_alu;

    // The branch decision is made in the datapath from PCWriteCond & zero.
    logic unused_zero;
    assign unused_zero = zero;

    assign rtype_alu = (func == 6'h20) || (func == 6'h24) || (func == 6'h27) ||
                       (func == 6'h2A) || (func == 6'h00);

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge value; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first so every path assigns state_d -- no latch.
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW))         state_d = S_MEM_ADDR;
                else if ((opcode == OP_RTYPE) && rtype_alu)         state_d = S_R_EX;
                else if ((opcode == OP_RTYPE) && (func == FN_JR))   state_d = S_JR;
                else if ((opcode == OP_ADDI) || (opcode == OP_ANDI)) state_d = S_I_EX;
                else if (opcode == OP_BEQ)                          state_d = S_BEQ;
                else if (opcode == OP_JAL)                          state_d = S_JAL;
                else                                                state_d = S_HALT;
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EX:     state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_I_EX:     state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_FETCH;
            S_JR:       state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs stay gated to zero while reset_n is low so no strobe escapes mid-reset.
    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        MemtoReg      = 2'b00;
        RegDst        = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        instr_retired = 1'b0;
        halted        = 1'b0;
        if (reset_n) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE:   ALUSrcB = 2'b11;
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite      = 1'b1;
                    MemtoReg      = 2'b01;
                    instr_retired = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite      = 1'b1;
                    IorD          = 1'b1;
                    instr_retired = mem_ready;
                end
                S_R_EX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_R_WB: begin
                    RegWrite      = 1'b1;
                    RegDst        = 2'b01;
                    instr_retired = 1'b1;
                end
                S_I_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
                end
                S_I_WB: begin
                    RegWrite      = 1'b1;
                    instr_retired = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA       = 1'b1;
                    ALUOp         = 2'b01;
                    PCWriteCond   = 1'b1;
                    PCSource      = 2'b01;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    RegWrite      = 1'b1;
                    RegDst        = 2'b10;
                    MemtoReg      = 2'b10;
                    PCWrite       = 1'b1;
                    PCSource      = 2'b10;
                    instr_retired = 1'b1;
                end
                S_JR: begin
                    PCWrite       = 1'b1;
                    PCSource      = 2'b11;
                    instr_retired = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed vector table, hand-written corner
// sequences, then random instruction streams against a path-level model.
module tb_mips_multicycle_control;

    logic       clock, reset_n;
    logic [5:0] opcode, func;
    logic       zero, mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] MemtoReg, RegDst, ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       instr_retired, halted;

    typedef struct packed {
        logic       pcw, pcwc, iord, memrd, memwr, irw, regw, srca;
        logic [1:0] memtoreg, regdst, srcb, aluop, pcsrc;
        logic [3:0] st;
        logic       retired, halt;
    } ctrl_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int          len;
        logic [19:0] seq;
    } vec_t;

    ctrl_t act;
    int    checks = 0, errors = 0;
    int    memwr_seen = 0, regw_seen = 0;
    int    path_q[$];
    vec_t  vecs[13];

    mips_multicycle_control dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .func(func),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state(state), .instr_retired(instr_retired), .halted(halted)
    );

    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                  MemtoReg, RegDst, ALUSrcB, ALUOp, PCSource, state, instr_retired, halted};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Control word the specification prescribes for a given state.
    function automatic ctrl_t exp_out(input int s, input logic [5:0] op, input logic rdy);
        ctrl_t e;
        e = '0;
        e.st = 4'(s);
        case (s)
            0:  begin e.memrd = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            1:  e.srcb = 2'b11;
            2:  begin e.srca = 1; e.srcb = 2'b10; end
            3:  begin e.memrd = 1; e.iord = 1; end
            4:  begin e.regw = 1; e.memtoreg = 2'b01; e.retired = 1; end
            5:  begin e.memwr = 1; e.iord = 1; e.retired = rdy; end
            6:  begin e.srca = 1; e.aluop = 2'b10; end
            7:  begin e.regw = 1; e.regdst = 2'b01; e.retired = 1; end
            8:  begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01; e.retired = 1; end
            9:  begin e.regw = 1; e.regdst = 2'b10; e.memtoreg = 2'b10; e.pcw = 1;
                      e.pcsrc = 2'b10; e.retired = 1; end
            10: begin e.pcw = 1; e.pcsrc = 2'b11; e.retired = 1; end
            11: begin e.srca = 1; e.srcb = 2'b10; e.aluop = (op == 6'h0C) ? 2'b11 : 2'b00; end
            12: begin e.regw = 1; e.retired = 1; end
            13: e.halt = 1;
            default: ;
        endcase
        return e;
    endfunction

    // Sequence of states an instruction walks through, ignoring memory stalls.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn);
        path_q = {0, 1};
        if (op == 6'h23)                                       path_q = {path_q, 2, 3, 4};
        else if (op == 6'h2B)                                  path_q = {path_q, 2, 5};
        else if (op == 6'h00 && fn inside {6'h20, 6'h24, 6'h27, 6'h2A, 6'h00})
                                                               path_q = {path_q, 6, 7};
        else if (op == 6'h00 && fn == 6'h08)                   path_q.push_back(10);
        else if (op == 6'h08 || op == 6'h0C)                   path_q = {path_q, 11, 12};
        else if (op == 6'h04)                                  path_q.push_back(8);
        else if (op == 6'h03)                                  path_q.push_back(9);
        else                                                   path_q.push_back(13);
    endtask

    // Entered and left on a falling edge: drive, settle, compare.
    task automatic step_check(input int s, input logic rdy, input string tag);
        mem_ready = rdy;
        zero = 1'($urandom);
        #1;
        check($sformatf("%s st%0d rdy%0d", tag, s, rdy), act, exp_out(s, opcode, rdy));
        memwr_seen += int'(MemWrite);
        regw_seen  += int'(RegWrite);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("outputs during reset", act, 32'h0);
        @(negedge clock);
        check("outputs held in reset", act, 32'h0);
        reset_n = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int max_wait);
        opcode = op;
        func = fn;
        plan(op, fn);
        foreach (path_q[k]) begin
            int s, w;
            s = path_q[k];
            if (s == 13) begin
                for (int h = 0; h < 5; h++) step_check(13, 1'($urandom), "rand halt");
                apply_reset();
                return;
            end
            if (s == 0 || s == 3 || s == 5) begin
                w = $urandom_range(0, max_wait);
                for (int j = 0; j < w; j++) step_check(s, 1'b0, "rand wait");
                step_check(s, 1'b1, "rand");
            end else begin
                step_check(s, 1'($urandom), "rand");
            end
        end
    endtask

    initial begin
        logic [5:0] legal_op[11];
        logic [5:0] legal_fn[11];
        int         sel;

        vecs[0]  = '{6'h23, 6'h00, 1'b0, 5, 20'h01234};
        vecs[1]  = '{6'h2B, 6'h00, 1'b0, 4, 20'h01250};
        vecs[2]  = '{6'h00, 6'h20, 1'b0, 4, 20'h01670};
        vecs[3]  = '{6'h00, 6'h24, 1'b1, 4, 20'h01670};
        vecs[4]  = '{6'h00, 6'h27, 1'b0, 4, 20'h01670};
        vecs[5]  = '{6'h00, 6'h2A, 1'b0, 4, 20'h01670};
        vecs[6]  = '{6'h00, 6'h00, 1'b0, 4, 20'h01670};
        vecs[7]  = '{6'h00, 6'h08, 1'b0, 3, 20'h01A00};
        vecs[8]  = '{6'h08, 6'h00, 1'b0, 4, 20'h01BC0};
        vecs[9]  = '{6'h0C, 6'h00, 1'b0, 4, 20'h01BC0};
        vecs[10] = '{6'h04, 6'h00, 1'b1, 3, 20'h01800};
        vecs[11] = '{6'h04, 6'h00, 1'b0, 3, 20'h01800};
        vecs[12] = '{6'h03, 6'h00, 1'b0, 3, 20'h01900};

        legal_op = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h04};
        legal_fn = '{6'h00, 6'h00, 6'h20, 6'h24, 6'h27, 6'h2A, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00};

        reset_n = 1'b0;
        opcode = 6'h00;
        func = 6'h00;
        zero = 1'b0;
        mem_ready = 1'b1;
        @(negedge clock);
        apply_reset();

        // Directed table, mem_ready held high: state path and latency per class.
        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            func = vecs[i].fn;
            for (int c = 0; c < vecs[i].len; c++) begin
                int s;
                s = int'(vecs[i].seq[19 - 4*c -: 4]);
                mem_ready = 1'b1;
                zero = vecs[i].z;
                #1;
                check($sformatf("vec%0d cyc%0d", i, c), act, exp_out(s, vecs[i].op, 1'b1));
                @(negedge clock);
            end
        end

        // sw with three stalled cycles in MEM_WR.
        opcode = 6'h2B;
        step_check(0, 1'b1, "sw");
        step_check(1, 1'b1, "sw");
        step_check(2, 1'b1, "sw");
        memwr_seen = 0;
        for (int j = 0; j < 3; j++) step_check(5, 1'b0, "sw stall");
        step_check(5, 1'b1, "sw ready");
        check("sw MemWrite cycles", 32'(memwr_seen), 32'd4);
        step_check(0, 1'b1, "after sw");
        opcode = 6'h00;
        func = 6'h20;
        step_check(1, 1'b1, "after sw");
        step_check(6, 1'b1, "after sw");
        step_check(7, 1'b1, "after sw");

        // Illegal opcode traps in HALT until reset.
        opcode = 6'h3F;
        step_check(0, 1'b1, "halt");
        step_check(1, 1'b1, "halt");
        for (int h = 0; h < 20; h++) step_check(13, 1'($urandom), "halt hold");
        apply_reset();
        step_check(0, 1'b1, "post halt");
        step_check(1, 1'b1, "post halt");
        step_check(13, 1'b1, "post halt");
        apply_reset();

        // Asynchronous reset partway through R_EX.
        opcode = 6'h00;
        func = 6'h24;
        step_check(0, 1'b1, "async");
        step_check(1, 1'b1, "async");
        mem_ready = 1'b1;
        #1;
        check("async R_EX before reset", act, exp_out(6, opcode, 1'b1));
        #2;
        regw_seen = 0;
        reset_n = 1'b0;
        #1;
        check("async reset immediate", act, 32'h0);
        @(posedge clock);
        #1;
        check("async reset across edge", act, 32'h0);
        regw_seen += int'(RegWrite);
        @(negedge clock);
        reset_n = 1'b1;
        step_check(0, 1'b1, "async recover");
        check("async no RegWrite", 32'(regw_seen), 32'd0);
        step_check(1, 1'b1, "async recover");
        step_check(6, 1'b1, "async recover");
        step_check(7, 1'b1, "async recover");

        // Random instruction stream with random memory stalls.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                run_instr(6'($urandom), 6'($urandom), 3);
            end else begin
                sel = $urandom_range(0, 11);
                if (sel == 11) run_instr(6'h03, 6'($urandom), 3);
                else           run_instr(legal_op[sel], legal_fn[sel], 3);
            end
        end
        step_check(0, 1'b0, "final fetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
